mem_io_bus: RTL and testbench

Memory/IO bus controller between `cpu` and the `RAM` instance in `lab7_top`. Decodes the CPU's `mem_cmd`/`mem_addr` requests, drives the synchronous-read RAM, and maps an LED output register and a switch input register into the 9-bit address space. Returns `read_data` to the CPU with a `mem_ready` completion pulse, so the CPU need not hard-code RAM latency.

---
 rtl/mem_io_pkg.sv | 29 ++
 rtl/mem_io_bus_sync2.sv | 33 +++
 rtl/mem_io_bus.sv | 142 ++++++++++++++
 tb/tb_mem_io_bus.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared definitions for the CPU memory/IO bus: command encodings,
// IO register addresses and the bus controller state encoding.
package mem_io_pkg;

  // CPU memory command encoding (11 is reserved/illegal)
  typedef enum logic [1:0] {
    MNONE    = 2'b00,
    MREAD    = 2'b01,
    MWRITE   = 2'b10,
    MILLEGAL = 2'b11
  } mem_cmd_e;

  // Memory-mapped IO register addresses
  localparam logic [8:0] MEM_LED_ADDR = 9'h100;
  localparam logic [8:0] MEM_SW_ADDR  = 9'h140;

  // Bus controller FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    DONE    = 2'b10
  } bus_state_e;

  // RAM occupies the lower half of the 9-bit address space
  function automatic logic addr_is_ram(input logic [8:0] addr);
    return (addr[8] == 1'b0);
  endfunction

endpackage

// File: rtl/mem_io_bus_sync2.sv
// Parameterised-width two-flop synchronizer for asynchronous inputs
// (slide switches). Each bit is synchronized independently.
module sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      // Two flops in series per bit; first stage may go metastable
      always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
          r_meta[gi] <= 1'b0;
          r_sync[gi] <= 1'b0;
        end else begin
          r_meta[gi] <= i_d[gi];
          r_sync[gi] <= r_meta[gi];
        end
      end
    end
  endgenerate

  assign o_q = r_sync;

endmodule

// File: rtl/mem_io_bus.sv
// Memory/IO bus controller between the CPU and the synchronous-read RAM.
// Decodes mem_cmd/mem_addr, drives the RAM, maps an LED output register
// and a synchronized switch input register, and signals completion of
// every read or write with a one-cycle mem_ready pulse.
module mem_io_bus
  import mem_io_pkg::*;
#(
  parameter int             ADDR_W   = 9,
  parameter int             DATA_W   = 16,
  parameter int             RAM_AW   = 8,
  parameter logic [ADDR_W-1:0] LED_ADDR = MEM_LED_ADDR,
  parameter logic [ADDR_W-1:0] SW_ADDR  = MEM_SW_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [7:0]        sw,
  output logic [7:0]        ledr
);

  bus_state_e        r_state;
  bus_state_e        w_state_next;
  logic [DATA_W-1:0] r_read_data;
  logic [7:0]        r_ledr;
  logic              r_bus_err;

  mem_cmd_e          w_cmd;
  logic [7:0]        w_sw_sync;
  logic              w_is_ram;
  logic              w_is_led;
  logic              w_is_sw;
  logic              w_idle;
  logic              w_wr_req;
  logic              w_led_wr;
  logic              w_bad_wr;
  logic              w_bad_cmd;
  logic              w_bad_rd;
  logic              w_rd_latch;
  logic [DATA_W-1:0] w_rd_src;

  // Switch inputs are asynchronous to clk
  sync2 #(.W(8)) u_sw_sync (
    .clk   (clk),
    .i_rst (reset),
    .i_d   (sw),
    .o_q   (w_sw_sync)
  );

  // Address decode; the CPU holds the address through the whole transaction
  assign w_cmd    = mem_cmd_e'(mem_cmd);
  assign w_is_ram = addr_is_ram(mem_addr);
  assign w_is_led = (mem_addr == LED_ADDR);
  assign w_is_sw  = (mem_addr == SW_ADDR);
  assign w_idle   = (r_state == IDLE);

  // Requests are only sampled in IDLE, so a command still held during
  // DONE can never trigger a second write
  assign w_wr_req   = w_idle && (w_cmd == MWRITE);
  assign w_led_wr   = w_wr_req && w_is_led;
  assign w_bad_wr   = w_wr_req && !w_is_ram && !w_is_led;
  assign w_bad_cmd  = w_idle && (w_cmd == MILLEGAL);
  assign w_rd_latch = (r_state == RD_WAIT);
  assign w_bad_rd   = w_rd_latch && !w_is_ram && !w_is_led && !w_is_sw;

  // RAM port: address and data pass straight through; the write enable is
  // forced low while reset is asserted
  assign ram_addr  = mem_addr[RAM_AW-1:0];
  assign ram_din   = write_data;
  assign ram_write = w_wr_req && w_is_ram && !reset;

  // Read data source select, evaluated in RD_WAIT when ram_dout is valid
  always_comb begin
    w_rd_src = '0;
    if (w_is_ram) begin
      w_rd_src = ram_dout;
    end else if (w_is_led) begin
      w_rd_src = {{(DATA_W-8){1'b0}}, r_ledr};
    end else if (w_is_sw) begin
      w_rd_src = {{(DATA_W-8){1'b0}}, w_sw_sync};
    end
  end

  // FSM next-state: reads take two cycles, writes one, illegal cmds none
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        case (w_cmd)
          MREAD:   w_state_next = RD_WAIT;
          MWRITE:  w_state_next = DONE;
          default: w_state_next = IDLE;
        endcase
      end
      RD_WAIT: w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Read result, LED register and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data <= '0;
      r_ledr      <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      if (w_rd_latch) begin
        r_read_data <= w_rd_src;
      end
      if (w_led_wr) begin
        r_ledr <= write_data[7:0];
      end
      if (w_bad_wr || w_bad_cmd || w_bad_rd) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign read_data = r_read_data;
  assign ledr      = r_ledr;
  assign bus_err   = r_bus_err;
  assign mem_ready = (r_state == DONE);

endmodule

// File: tb/tb_mem_io_bus.sv
// Directed self-checking bench for mem_io_bus with a behavioural
// synchronous-read RAM attached to the RAM port.
module tb_mem_io_bus;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        bus_err;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [7:0]  sw;
  logic [7:0]  ledr;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  logic [15:0] tb_mem [256];

  mem_io_bus dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_ready  (mem_ready),
    .bus_err    (bus_err),
    .ram_addr   (ram_addr),
    .ram_write  (ram_write),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .sw         (sw),
    .ledr       (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model and write counter
  always @(posedge clk) begin
    if (ram_write) begin
      tb_mem[ram_addr] <= ram_din;
      wr_count <= wr_count + 1;
    end
    ram_dout <= tb_mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    mem_cmd    = c;
    mem_addr   = a;
    write_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(2'b10, 9'h000, 16'hFFFF);
    step();
    step();
    checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL reset_read_data got %h want 0000", read_data); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready got %b want 0", mem_ready); end
    checks++; if (ledr !== 8'h00) begin errors++; $display("FAIL reset_ledr got %h want 00", ledr); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
    checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL reset_ram_write got %b want 0", ram_write); end
    drive(2'b00, 9'h000, 16'h0000);
    reset = 1'b0;
    step();
    $display("reset: read_data=%h ledr=%h bus_err=%b", read_data, ledr, bus_err);
  endtask

  task automatic test_ram_roundtrip();
    drive(2'b10, 9'h005, 16'hBEEF);
    #1;
    checks++; if (ram_write !== 1'b1) begin errors++; $display("FAIL ram_wr_enable got %b want 1", ram_write); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL ram_wr_ready_early got %b want 0", mem_ready); end
    step();
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL ram_wr_ready got %b want 1", mem_ready); end
    checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL ram_wr_done_no_write got %b want 0", ram_write); end
    drive(2'b00, 9'h000, 16'h0000);
    step();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL ram_wr_ready_single got %b want 0", mem_ready); end
    drive(2'b01, 9'h005, 16'h0000);
    step();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL ram_rd_wait_ready got %b want 0", mem_ready); end
    step();
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL ram_rd_ready got %b want 1", mem_ready); end
    checks++; if (read_data !== 16'hBEEF) begin errors++; $display("FAIL ram_rd_data got %h want BEEF", read_data); end
    drive(2'b00, 9'h000, 16'h0000);
    step();
    $display("ram roundtrip: wrote BEEF @005, read %h", read_data);
  endtask

  task automatic test_led();
    drive(2'b10, 9'h100, 16'h12A5);
    #1;
    checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL led_no_ram_write got %b want 0", ram_write); end
    step();
    checks++; if (ledr !== 8'hA5) begin errors++; $display("FAIL led_value got %h want A5", ledr); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL led_wr_ready got %b want 1", mem_ready); end
    drive(2'b00, 9'h000, 16'h0000);
    step();
    drive(2'b01, 9'h100, 16'h0000);
    step();
    step();
    checks++; if (read_data !== 16'h00A5) begin errors++; $display("FAIL led_readback got %h want 00A5", read_data); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL led_no_err got %b want 0", bus_err); end
    drive(2'b00, 9'h000, 16'h0000);
    step();
    $display("led: ledr=%h readback=%h", ledr, read_data);
  endtask

  task automatic test_reset_mid_read();
    int ready_seen;
    ready_seen = 0;
    drive(2'b01, 9'h005, 16'h0000);
    step();
    reset = 1'b1;
    #1;
    checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL midrst_read_data got %h want 0000", read_data); end
    checks++; if (ledr !== 8'h00) begin errors++; $display("FAIL midrst_ledr got %h want 00", ledr); end
    step();
    drive(2'b00, 9'h000, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mem_ready === 1'b1) ready_seen++;
      step();
    end
    checks++; if (ready_seen != 0) begin errors++; $display("FAIL midrst_no_ready got %0d pulses want 0", ready_seen); end
    checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL midrst_discard got %h want 0000", read_data); end
    $display("reset mid-read: read_data=%h ledr=%h ready_pulses=%0d", read_data, ledr, ready_seen);
  endtask

  task automatic test_switches();
    sw = 8'h3C;
    step();
    step();
    step();
    drive(2'b01, 9'h140, 16'h0000);
    step();
    step();
    checks++; if (read_data !== 16'h003C) begin errors++; $display("FAIL sw_read got %h want 003C", read_data); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL sw_ready got %b want 1", mem_ready); end
    drive(2'b00, 9'h000, 16'h0000);
    step();
    drive(2'b10, 9'h140, 16'h00FF);
    #1;
    checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL sw_wr_no_ram got %b want 0", ram_write); end
    step();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL sw_wr_err got %b want 1", bus_err); end
    checks++; if (ledr !== 8'h00) begin errors++; $display("FAIL sw_wr_ledr got %h want 00", ledr); end
    drive(2'b00, 9'h000, 16'h0000);
    step();
    $display("switches: read=%h bus_err=%b ledr=%h", read_data, bus_err, ledr);
  endtask

  task automatic test_errors();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", bus_err); end
    drive(2'b01, 9'h005, 16'h0000);
    step();
    step();
    checks++; if (read_data !== 16'hBEEF) begin errors++; $display("FAIL err_pre_read got %h want BEEF", read_data); end
    drive(2'b00, 9'h000, 16'h0000);
    step();
    drive(2'b01, 9'h1F0, 16'h0000);
    step();
    step();
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL err_unmapped_ready got %b want 1", mem_ready); end
    checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL err_unmapped_data got %h want 0000", read_data); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL err_unmapped_flag got %b want 1", bus_err); end
    drive(2'b00, 9'h000, 16'h0000);
    step();
    drive(2'b11, 9'h005, 16'h5555);
    #1;
    checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL err_illegal_no_write got %b want 0", ram_write); end
    step();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL err_illegal_ready got %b want 0", mem_ready); end
    step();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL err_illegal_ready2 got %b want 0", mem_ready); end
    drive(2'b00, 9'h000, 16'h0000);
    step();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus_err); end
    $display("errors: read_data=%h bus_err=%b", read_data, bus_err);
  endtask

  task automatic test_back_to_back();
    int wr_start;
    wr_start = wr_count;
    drive(2'b10, 9'h010, 16'h1234);
    step();
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready got %b want 1", mem_ready); end
    checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL b2b_held_no_write got %b want 0", ram_write); end
    step();
    drive(2'b01, 9'h010, 16'h0000);
    #1;
    checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL b2b_rd_no_write got %b want 0", ram_write); end
    step();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL b2b_rd_wait got %b want 0", mem_ready); end
    step();
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready got %b want 1", mem_ready); end
    checks++; if (read_data !== 16'h1234) begin errors++; $display("FAIL b2b_rd_data got %h want 1234", read_data); end
    drive(2'b00, 9'h000, 16'h0000);
    step();
    checks++; if ((wr_count - wr_start) != 1) begin errors++; $display("FAIL b2b_write_count got %0d want 1", wr_count - wr_start); end
    $display("back-to-back: read=%h writes=%0d", read_data, wr_count - wr_start);
  endtask

  initial begin
    reset = 1'b1;
    sw    = 8'h00;
    drive(2'b00, 9'h000, 16'h0000);
    test_reset();
    test_ram_roundtrip();
    test_led();
    test_reset_mid_read();
    test_switches();
    test_errors();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
